// File: rtl/multisim_axi_arbiter.sv
// Round-robin arbiter sharing one AXI manager port between N_MASTERS single-beat managers.
// Optional per-master completion counters when MULTISIM_AXI_ARB_STATS_EN is defined.
module multisim_axi_arbiter #(
   parameter int unsigned N_MASTERS = 4,
   parameter type axi_aw_t = logic,
   parameter type axi_w_t  = logic,
   parameter type axi_b_t  = logic,
   parameter type axi_ar_t = logic,
   parameter type axi_r_t  = logic
) (
   input  logic                 clk,
   input  logic                 rst,
   // per-master subordinate side
   input  axi_aw_t              i_axi_s_aw [N_MASTERS],
   input  logic [N_MASTERS-1:0] i_axi_s_awvalid,
   output logic [N_MASTERS-1:0] o_axi_s_awready,
   input  axi_w_t               i_axi_s_w [N_MASTERS],
   input  logic [N_MASTERS-1:0] i_axi_s_wvalid,
   output logic [N_MASTERS-1:0] o_axi_s_wready,
   output axi_b_t               o_axi_s_b [N_MASTERS],
   output logic [N_MASTERS-1:0] o_axi_s_bvalid,
   input  logic [N_MASTERS-1:0] i_axi_s_bready,
   input  axi_ar_t              i_axi_s_ar [N_MASTERS],
   input  logic [N_MASTERS-1:0] i_axi_s_arvalid,
   output logic [N_MASTERS-1:0] o_axi_s_arready,
   output axi_r_t               o_axi_s_r [N_MASTERS],
   output logic [N_MASTERS-1:0] o_axi_s_rvalid,
   input  logic [N_MASTERS-1:0] i_axi_s_rready,
   // shared downstream port
   output axi_aw_t              o_axi_m_aw,
   output logic                 o_axi_m_awvalid,
   input  logic                 i_axi_m_awready,
   output axi_w_t               o_axi_m_w,
   output logic                 o_axi_m_wvalid,
   input  logic                 i_axi_m_wready,
   input  axi_b_t               i_axi_m_b,
   input  logic                 i_axi_m_bvalid,
   output logic                 o_axi_m_bready,
   output axi_ar_t              o_axi_m_ar,
   output logic                 o_axi_m_arvalid,
   input  logic                 i_axi_m_arready,
   input  axi_r_t               i_axi_m_r,
   input  logic                 i_axi_m_rvalid,
   output logic                 o_axi_m_rready
`ifdef MULTISIM_AXI_ARB_STATS_EN
   ,
   output logic [31:0]          o_wr_grants [N_MASTERS],
   output logic [31:0]          o_rd_grants [N_MASTERS]
`endif
);

   localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {WIdle, WAddr, WResp} wr_state_e;
   typedef enum logic [1:0] {RIdle, RAddr, RResp} rd_state_e;

   wr_state_e w_state_q, w_state_d;
   rd_state_e r_state_q, r_state_d;
   idx_t      w_grant_q, w_grant_d, w_rr_q, w_rr_d;
   idx_t      r_grant_q, r_grant_d, r_rr_q, r_rr_d;
   logic      aw_done_q, aw_done_d, w_done_q, w_done_d;

   // First requester at or after ptr, wrapping past N_MASTERS-1.
   function automatic idx_t rr_pick(input logic [N_MASTERS-1:0] req, input idx_t ptr);
      idx_t        pick;
      logic        found;
      int unsigned k;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         k = (32'(ptr) + i) % N_MASTERS;
         if (!found && req[idx_t'(k)]) begin
            found = 1'b1;
            pick  = idx_t'(k);
         end
      end
      return pick;
   endfunction

   function automatic idx_t next_ptr(input idx_t g);
      return (32'(g) == N_MASTERS - 1) ? '0 : g + idx_t'(1);
   endfunction

   // ---------------- write path ----------------
   always_comb begin
      w_state_d       = w_state_q;
      w_grant_d       = w_grant_q;
      w_rr_d          = w_rr_q;
      aw_done_d       = aw_done_q;
      w_done_d        = w_done_q;
      o_axi_s_awready = '0;
      o_axi_s_wready  = '0;
      o_axi_s_bvalid  = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         o_axi_s_b[i] = '0;
      end
      o_axi_m_aw      = '0;
      o_axi_m_awvalid = 1'b0;
      o_axi_m_w       = '0;
      o_axi_m_wvalid  = 1'b0;
      o_axi_m_bready  = 1'b0;
      unique case (w_state_q)
         WIdle: begin
            if (|i_axi_s_awvalid) begin
               w_grant_d = rr_pick(i_axi_s_awvalid, w_rr_q);
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               w_state_d = WAddr;
            end
         end
         WAddr: begin
            o_axi_m_aw                 = i_axi_s_aw[w_grant_q];
            o_axi_m_awvalid            = i_axi_s_awvalid[w_grant_q] & ~aw_done_q;
            o_axi_s_awready[w_grant_q] = i_axi_m_awready & ~aw_done_q;
            o_axi_m_w                  = i_axi_s_w[w_grant_q];
            o_axi_m_wvalid             = i_axi_s_wvalid[w_grant_q] & ~w_done_q;
            o_axi_s_wready[w_grant_q]  = i_axi_m_wready & ~w_done_q;
            // AW and W may complete in either order or together
            aw_done_d = aw_done_q | (o_axi_m_awvalid & i_axi_m_awready);
            w_done_d  = w_done_q | (o_axi_m_wvalid & i_axi_m_wready);
            if (aw_done_d && w_done_d) begin
               w_state_d = WResp;
            end
         end
         WResp: begin
            o_axi_s_b[w_grant_q]      = i_axi_m_b;
            o_axi_s_bvalid[w_grant_q] = i_axi_m_bvalid;
            o_axi_m_bready            = i_axi_s_bready[w_grant_q];
            if (i_axi_m_bvalid && i_axi_s_bready[w_grant_q]) begin
               w_state_d = WIdle;
               w_rr_d    = next_ptr(w_grant_q);
            end
         end
         default: w_state_d = WIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= WIdle;
         w_grant_q <= '0;
         w_rr_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_grant_q <= w_grant_d;
         w_rr_q    <= w_rr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // ---------------- read path ----------------
   always_comb begin
      r_state_d       = r_state_q;
      r_grant_d       = r_grant_q;
      r_rr_d          = r_rr_q;
      o_axi_s_arready = '0;
      o_axi_s_rvalid  = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         o_axi_s_r[i] = '0;
      end
      o_axi_m_ar      = '0;
      o_axi_m_arvalid = 1'b0;
      o_axi_m_rready  = 1'b0;
      unique case (r_state_q)
         RIdle: begin
            if (|i_axi_s_arvalid) begin
               r_grant_d = rr_pick(i_axi_s_arvalid, r_rr_q);
               r_state_d = RAddr;
            end
         end
         RAddr: begin
            o_axi_m_ar                 = i_axi_s_ar[r_grant_q];
            o_axi_m_arvalid            = i_axi_s_arvalid[r_grant_q];
            o_axi_s_arready[r_grant_q] = i_axi_m_arready;
            if (o_axi_m_arvalid && i_axi_m_arready) begin
               r_state_d = RResp;
            end
         end
         RResp: begin
            o_axi_s_r[r_grant_q]      = i_axi_m_r;
            o_axi_s_rvalid[r_grant_q] = i_axi_m_rvalid;
            o_axi_m_rready            = i_axi_s_rready[r_grant_q];
            if (i_axi_m_rvalid && i_axi_s_rready[r_grant_q]) begin
               r_state_d = RIdle;
               r_rr_d    = next_ptr(r_grant_q);
            end
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= RIdle;
         r_grant_q <= '0;
         r_rr_q    <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_grant_q <= r_grant_d;
         r_rr_q    <= r_rr_d;
      end
   end

`ifdef MULTISIM_AXI_ARB_STATS_EN
   logic        wr_done, rd_done;
   logic [31:0] wr_cnt_q [N_MASTERS];
   logic [31:0] rd_cnt_q [N_MASTERS];

   assign wr_done = (w_state_q == WResp) & i_axi_m_bvalid & i_axi_s_bready[w_grant_q];
   assign rd_done = (r_state_q == RResp) & i_axi_m_rvalid & i_axi_s_rready[r_grant_q];

   // 32-bit counters wrap naturally at 2^32-1 -> 0
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_MASTERS; i++) begin
            wr_cnt_q[i] <= '0;
            rd_cnt_q[i] <= '0;
         end
      end else begin
         if (wr_done) begin
            wr_cnt_q[w_grant_q] <= wr_cnt_q[w_grant_q] + 32'd1;
         end
         if (rd_done) begin
            rd_cnt_q[r_grant_q] <= rd_cnt_q[r_grant_q] + 32'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_MASTERS; i++) begin
         o_wr_grants[i] = wr_cnt_q[i];
         o_rd_grants[i] = rd_cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_multisim_axi_arbiter.sv
// Self-checking bench for multisim_axi_arbiter: transaction-level ownership model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_multisim_axi_arbiter;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0] s_aw [N];
   logic [31:0] s_w  [N];
   logic [7:0]  s_b  [N];
   logic [31:0] s_ar [N];
   logic [31:0] s_r  [N];
   logic [N-1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [N-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
   logic [31:0] m_aw, m_w, m_ar, m_r;
   logic [7:0]  m_b;
   logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic m_arvalid, m_arready, m_rvalid, m_rready;
`ifdef MULTISIM_AXI_ARB_STATS_EN
   logic [31:0] wr_grants [N];
   logic [31:0] rd_grants [N];
`endif

   multisim_axi_arbiter #(
      .N_MASTERS(N), .axi_aw_t(logic [31:0]), .axi_w_t(logic [31:0]),
      .axi_b_t(logic [7:0]), .axi_ar_t(logic [31:0]), .axi_r_t(logic [31:0])
   ) dut (
      .clk(clk), .rst(rst),
      .i_axi_s_aw(s_aw), .i_axi_s_awvalid(s_awvalid), .o_axi_s_awready(s_awready),
      .i_axi_s_w(s_w), .i_axi_s_wvalid(s_wvalid), .o_axi_s_wready(s_wready),
      .o_axi_s_b(s_b), .o_axi_s_bvalid(s_bvalid), .i_axi_s_bready(s_bready),
      .i_axi_s_ar(s_ar), .i_axi_s_arvalid(s_arvalid), .o_axi_s_arready(s_arready),
      .o_axi_s_r(s_r), .o_axi_s_rvalid(s_rvalid), .i_axi_s_rready(s_rready),
      .o_axi_m_aw(m_aw), .o_axi_m_awvalid(m_awvalid), .i_axi_m_awready(m_awready),
      .o_axi_m_w(m_w), .o_axi_m_wvalid(m_wvalid), .i_axi_m_wready(m_wready),
      .i_axi_m_b(m_b), .i_axi_m_bvalid(m_bvalid), .o_axi_m_bready(m_bready),
      .o_axi_m_ar(m_ar), .o_axi_m_arvalid(m_arvalid), .i_axi_m_arready(m_arready),
      .i_axi_m_r(m_r), .i_axi_m_rvalid(m_rvalid), .o_axi_m_rready(m_rready)
`ifdef MULTISIM_AXI_ARB_STATS_EN
      , .o_wr_grants(wr_grants), .o_rd_grants(rd_grants)
`endif
   );

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---- transaction-level model: who owns each path, and what it has completed ----
   int wo = -1, ws = 0, wnext = 0, ro = -1, rs = 0, rnext = 0;
   bit was = 1'b0, wws = 1'b0;

   function automatic int first_at(input logic [N-1:0] req, input int p);
      for (int i = 0; i < N; i++) begin
         if (req[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] bit_of(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         wo = -1; ro = -1; wnext = 0; rnext = 0;
      end else begin
         if (wo < 0) begin
            if (|s_awvalid) begin
               wo = first_at(s_awvalid, wnext); ws = 0; was = 1'b0; wws = 1'b0;
            end
         end else if (ws == 0) begin
            if (s_awvalid[wo] && m_awready) was = 1'b1;
            if (s_wvalid[wo] && m_wready) wws = 1'b1;
            if (was && wws) ws = 1;
         end else if (m_bvalid && s_bready[wo]) begin
            wnext = (wo + 1) % N; wo = -1;
         end
         if (ro < 0) begin
            if (|s_arvalid) begin
               ro = first_at(s_arvalid, rnext); rs = 0;
            end
         end else if (rs == 0) begin
            if (s_arvalid[ro] && m_arready) rs = 1;
         end else if (m_rvalid && s_rready[ro]) begin
            rnext = (ro + 1) % N; ro = -1;
         end
      end
   end

   // ---- per-cycle compare against the model ----
   bit w_addr, w_resp, r_addr, r_resp;
   always @(negedge clk) begin
      if (chk_on) begin
         w_addr = (wo >= 0) && (ws == 0);
         w_resp = (wo >= 0) && (ws == 1);
         r_addr = (ro >= 0) && (rs == 0);
         r_resp = (ro >= 0) && (rs == 1);
         chk("m_awvalid", m_awvalid, (w_addr && !was) ? s_awvalid[wo] : 1'b0);
         chk("m_wvalid", m_wvalid, (w_addr && !wws) ? s_wvalid[wo] : 1'b0);
         chk("s_awready", s_awready, (w_addr && !was && m_awready) ? bit_of(wo) : '0);
         chk("s_wready", s_wready, (w_addr && !wws && m_wready) ? bit_of(wo) : '0);
         chk("s_bvalid", s_bvalid, (w_resp && m_bvalid) ? bit_of(wo) : '0);
         chk("m_bready", m_bready, w_resp ? s_bready[wo] : 1'b0);
         if (w_addr && !was && s_awvalid[wo]) chk("m_aw", m_aw, s_aw[wo]);
         if (w_addr && !wws && s_wvalid[wo]) chk("m_w", m_w, s_w[wo]);
         chk("m_arvalid", m_arvalid, r_addr ? s_arvalid[ro] : 1'b0);
         chk("s_arready", s_arready, (r_addr && m_arready) ? bit_of(ro) : '0);
         chk("s_rvalid", s_rvalid, (r_resp && m_rvalid) ? bit_of(ro) : '0);
         chk("m_rready", m_rready, r_resp ? s_rready[ro] : 1'b0);
         if (r_addr && s_arvalid[ro]) chk("m_ar", m_ar, s_ar[ro]);
         for (int i = 0; i < N; i++) begin
            chk($sformatf("s_b[%0d]", i), s_b[i], (w_resp && wo == i) ? m_b : 8'h00);
            chk($sformatf("s_r[%0d]", i), s_r[i], (r_resp && ro == i) ? m_r : 32'h0);
         end
      end
   end

   // ---- masters drop valid after handshake; downstream responder ----
   int wr_log[$];
   int rd_log[$];
   logic [7:0]  last_b [N];
   logic [31:0] last_r [N];
   logic [N-1:0] aw_hs, w_hs, ar_hs;
   logic maw, mw, mar, mb, mr;
   logic got_aw = 1'b0, got_w = 1'b0;
   logic [31:0] tag_aw = '0, tag_ar = '0;

   initial begin
      forever begin
         @(negedge clk);
         aw_hs = s_awvalid & s_awready;
         w_hs  = s_wvalid & s_wready;
         ar_hs = s_arvalid & s_arready;
         maw = m_awvalid & m_awready;
         mw  = m_wvalid & m_wready;
         mar = m_arvalid & m_arready;
         mb  = m_bvalid & m_bready;
         mr  = m_rvalid & m_rready;
         for (int i = 0; i < N; i++) begin
            if (s_bvalid[i] && s_bready[i]) begin wr_log.push_back(i); last_b[i] = s_b[i]; end
            if (s_rvalid[i] && s_rready[i]) begin rd_log.push_back(i); last_r[i] = s_r[i]; end
         end
         if (maw) tag_aw = m_aw;
         if (mar) tag_ar = m_ar;
         @(posedge clk);
         #1;
         if (rst) begin
            m_bvalid = 1'b0; m_rvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0;
         end else begin
            s_awvalid = s_awvalid & ~aw_hs;
            s_wvalid  = s_wvalid & ~w_hs;
            s_arvalid = s_arvalid & ~ar_hs;
            if (mb) m_bvalid = 1'b0;
            if (mr) m_rvalid = 1'b0;
            if (maw) got_aw = 1'b1;
            if (mw) got_w = 1'b1;
            if (got_aw && got_w && !m_bvalid) begin
               m_b = tag_aw[7:0] ^ 8'h5A; m_bvalid = 1'b1; got_aw = 1'b0; got_w = 1'b0;
            end
            if (mar) begin m_r = tag_ar ^ 32'hA5A5_0000; m_rvalid = 1'b1; end
         end
      end
   end

   // ---- directed stimulus ----
   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic wr(input int m, input logic [31:0] a, input logic [31:0] d);
      s_aw[m] = a; s_w[m] = d; s_awvalid[m] = 1'b1; s_wvalid[m] = 1'b1;
   endtask

   task automatic rd(input int m, input logic [31:0] a);
      s_ar[m] = a; s_arvalid[m] = 1'b1;
   endtask

   task automatic wait_log(input bit is_rd, input int n, input string nm);
      int b = 0;
      while (((is_rd ? rd_log.size() : wr_log.size()) < n) && b < 200) begin cyc(1); b++; end
      checks++;
      if ((is_rd ? rd_log.size() : wr_log.size()) < n) begin
         errors++;
         $display("FAIL %s: timeout, got %0d completions, want %0d", nm,
                  is_rd ? rd_log.size() : wr_log.size(), n);
      end
   endtask

   task automatic do_reset();
      s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   int base;
   int exp_order [5] = '{0, 1, 2, 3, 0};

   initial begin
      rst = 1'b1;
      s_aw = '{default: '0}; s_w = '{default: '0}; s_ar = '{default: '0};
      last_b = '{default: '0}; last_r = '{default: '0};
      s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
      s_bready = '1; s_rready = '1;
      m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
      m_bvalid = 1'b0; m_rvalid = 1'b0; m_b = '0; m_r = '0;
      cyc(1);
      chk_on = 1'b1;
      cyc(1);
      chk("rst m_awvalid", m_awvalid, 1'b0);
      chk("rst s_awready", s_awready, 4'b0000);
      chk("rst m_arvalid", m_arvalid, 1'b0);
      rst = 1'b0;
      cyc(1);

      // single master 2, two writes; grant visible the cycle after the request
      wr(2, 32'h100, 32'hDEAD_0001);
      cyc(1);
      chk("grant t+1 awvalid", m_awvalid, 1'b1);
      chk("grant t+1 awready", s_awready, 4'b0100);
      wait_log(1'b0, 1, "m2 write 1");
      chk("m2 b payload 1", last_b[2], 8'h5A);
      wr(2, 32'h104, 32'hDEAD_0002);
      wait_log(1'b0, 2, "m2 write 2");
      chk("m2 b payload 2", last_b[2], 8'h5E);
      chk("m2 log 0", wr_log[0], 2);
      chk("m2 log 1", wr_log[1], 2);

      // all four at once from a fresh pointer, master 0 re-requests after its B
      do_reset();
      base = wr_log.size();
      for (int m = 0; m < N; m++) wr(m, 32'h200 + 32'(m * 4), 32'h1000 + 32'(m));
      wait_log(1'b0, base + 1, "rr first");
      wr(0, 32'h300, 32'h2000);
      wait_log(1'b0, base + 5, "rr all");
      for (int i = 0; i < 5; i++) chk($sformatf("rr order %0d", i), wr_log[base + i], exp_order[i]);

      // master 1: W three cycles ahead of AW, then AW stalled downstream
      s_w[1] = 32'hCAFE_0001; s_wvalid[1] = 1'b1;
      cyc(3);
      m_awready = 1'b0;
      s_aw[1] = 32'h1F0; s_awvalid[1] = 1'b1;
      cyc(2);
      chk("w-first awvalid", m_awvalid, 1'b1);
      chk("w-first wvalid", m_wvalid, 1'b0);
      chk("w-first bvalid", s_bvalid, 4'b0000);
      cyc(1);
      m_awready = 1'b1;
      wait_log(1'b0, base + 6, "w-first write");
      chk("w-first owner", wr_log[base + 5], 1);

      // concurrent read from 0 and write from 3
      rd(0, 32'h200);
      wr(3, 32'h4C4, 32'hBEEF_0003);
      wait_log(1'b1, rd_log.size() + 1, "concurrent read");
      wait_log(1'b0, base + 7, "concurrent write");
      chk("conc r owner", rd_log[rd_log.size() - 1], 0);
      chk("conc b owner", wr_log[base + 6], 3);
      chk("conc r payload", last_r[0], 32'hA5A5_0200);
      chk("conc b payload", last_b[3], 8'h9E);

      // reset while in W_RESP; pointer must return to 0
      wr(1, 32'h10, 32'h1);
      wait_log(1'b0, base + 8, "pre-reset write");
      s_bready[2] = 1'b0;
      wr(2, 32'h20, 32'h2);
      begin
         int b = 0;
         while (!s_bvalid[2] && b < 50) begin cyc(1); b++; end
         chk("reach W_RESP", s_bvalid[2], 1'b1);
      end
      rst = 1'b1;
      cyc(1);
      chk("mid-reset bvalid", s_bvalid, 4'b0000);
      chk("mid-reset bready", m_bready, 1'b0);
      chk("mid-reset awvalid", m_awvalid, 1'b0);
      rst = 1'b0;
      s_bready = '1;
      wr(0, 32'h30, 32'h3);
      wr(3, 32'h40, 32'h4);
      wait_log(1'b0, base + 9, "post-reset write");
      chk("post-reset grant", wr_log[base + 8], 0);
      wait_log(1'b0, base + 10, "post-reset write 2");
      chk("post-reset next", wr_log[base + 9], 3);

`ifdef MULTISIM_AXI_ARB_STATS_EN
      do_reset();
      for (int k = 0; k < 5; k++) begin
         wr(1, 32'h500 + 32'(k), 32'(k));
         wait_log(1'b0, wr_log.size() + 1, "stats write");
      end
      for (int k = 0; k < 2; k++) begin
         rd(2, 32'h600 + 32'(k));
         wait_log(1'b1, rd_log.size() + 1, "stats read");
      end
      cyc(1);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("wr_grants[%0d]", i), wr_grants[i], (i == 1) ? 32'd5 : 32'd0);
         chk($sformatf("rd_grants[%0d]", i), rd_grants[i], (i == 2) ? 32'd2 : 32'd0);
      end
`endif

      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
